perf_event_counter: RTL and testbench

Synthesizable pipeline performance monitor for the pipelined CPU. It counts NUM_EVT single-bit pipeline events (stall, flush, retire, branch-taken, ...) plus elapsed run cycles between start and an optional cycle limit. Counts can be snapshotted into shadow registers and read out per channel. It sits beside the CPU top level and is fed by hazard-detection, IF/ID flush and WB-stage strobes.

---
 rtl/perf_pkg.sv | 20 ++
 rtl/perf_cnt_slice.sv | 41 ++++
 rtl/perf_event_counter.sv | 103 ++++++++++
 tb/tb_perf_event_counter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared types and constants for the pipeline performance monitor.
package perf_pkg;

  typedef enum logic [1:0] {
    PERF_IDLE = 2'd0,
    PERF_RUN  = 2'd1,
    PERF_DONE = 2'd2
  } perf_state_e;

  localparam int EVT_RETIRE = 0;
  localparam int EVT_STALL  = 1;
  localparam int EVT_FLUSH  = 2;
  localparam int EVT_BRANCH = 3;

  function automatic logic [63:0] cnt_max(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/perf_cnt_slice.sv
// One unsigned event counter with wrap/saturate policy and a sticky overflow flag.
module perf_cnt_slice
  import perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             sat_mode,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] nxt,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic at_max;

  // nxt is exported so the top can snapshot the post-increment value on the final run cycle
  always_comb begin
    at_max = (value == MAX);
    nxt    = value;
    if (inc) begin
      if (!at_max)        nxt = value + 1'b1;
      else if (!sat_mode) nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
      ovf   <= 1'b0;
    end else begin
      value <= nxt;
      if (inc && at_max) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/perf_event_counter.sv
// Pipeline performance monitor: NUM_EVT event counters plus a run-cycle counter,
// with limit-terminated runs, shadow snapshots and per-channel readout.
module perf_event_counter
  import perf_pkg::*;
#(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               enable_i,
  input  logic               sat_mode_i,
  input  logic [CNT_W-1:0]   limit_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               snap_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic [CNT_W-1:0]   cycle_o,
  output logic               snap_valid_o,
  output logic               running_o,
  output logic               done_o,
  output logic [NUM_EVT:0]   ovf_o
);

  localparam int NCH = NUM_EVT + 1;

  perf_state_e      state;
  logic [CNT_W-1:0] lim_q;
  logic             sat_q;
  logic             snap_vld_q;
  logic [CNT_W-1:0] live   [NCH];
  logic [CNT_W-1:0] nxt    [NCH];
  logic [CNT_W-1:0] shadow [NCH];
  logic [NCH-1:0]   ovf;
  logic [NCH-1:0]   inc;
  logic             clr_live;
  logic             cnt_en;
  logic             hit_lim;

  // start and clear both zero the live counters; neither counts on its own edge
  assign clr_live = clear_i | start_i;
  assign cnt_en   = (state == PERF_RUN) && enable_i && !clr_live;
  assign inc      = {cnt_en, evt_i & {NUM_EVT{cnt_en}}};
  assign hit_lim  = cnt_en && (lim_q != '0) && (nxt[NUM_EVT] == lim_q);

  for (genvar k = 0; k < NCH; k++) begin : g_slice
    perf_cnt_slice #(.CNT_W(CNT_W)) u_slice (
      .clk      (clk_i),
      .rst      (rst_i),
      .clr      (clr_live),
      .inc      (inc[k]),
      .sat_mode (sat_q),
      .value    (live[k]),
      .nxt      (nxt[k]),
      .ovf      (ovf[k])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= PERF_IDLE;
      lim_q <= '0;
      sat_q <= 1'b0;
    end else if (clear_i) begin
      state <= PERF_IDLE;
    end else if (start_i) begin
      state <= PERF_RUN;
      lim_q <= limit_i;
      sat_q <= sat_mode_i;
    end else if (hit_lim) begin
      state <= PERF_DONE;
    end
  end

  // Auto-snapshot at run end takes post-increment values; a manual snap takes pre-increment ones
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      snap_vld_q <= 1'b0;
      for (int k = 0; k < NCH; k++) shadow[k] <= '0;
    end else if (hit_lim) begin
      snap_vld_q <= 1'b1;
      for (int k = 0; k < NCH; k++) shadow[k] <= nxt[k];
    end else if (snap_i) begin
      snap_vld_q <= 1'b1;
      for (int k = 0; k < NCH; k++) shadow[k] <= live[k];
    end
  end

  always_comb begin
    cnt_o = '0;
    if (int'(sel_i) < NUM_EVT) cnt_o = shadow[sel_i];
  end

  assign cycle_o      = shadow[NUM_EVT];
  assign snap_valid_o = snap_vld_q;
  assign running_o    = (state == PERF_RUN);
  assign done_o       = (state == PERF_DONE);
  assign ovf_o        = ovf;

endmodule

// File: tb/tb_perf_event_counter.sv
// Bench for perf_event_counter: a 32-bit and a 4-bit instance share stimulus and are
// compared against a cycle-level reference model of the measurement rules.
module tb_perf_event_counter;
  import perf_pkg::*;

  localparam int NE  = 4;
  localparam int NCH = NE + 1;
  localparam int WW  = 32;
  localparam int NW  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0, start = 1'b0, clear = 1'b0, enable = 1'b0;
  logic          sat_mode = 1'b0, snap = 1'b0;
  logic [WW-1:0] limit = '0;
  logic [NW-1:0] limit_n;
  logic [NE-1:0] evt = '0;
  logic [1:0]    sel = '0;

  logic [WW-1:0] w_cnt, w_cyc;
  logic [NW-1:0] n_cnt, n_cyc;
  logic          w_sv, w_run, w_done, n_sv, n_run, n_done;
  logic [NE:0]   w_ovf, n_ovf;

  assign limit_n = limit[NW-1:0];

  perf_event_counter #(.NUM_EVT(NE), .CNT_W(WW)) u_wide (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .enable_i(enable),
    .sat_mode_i(sat_mode), .limit_i(limit), .evt_i(evt), .snap_i(snap), .sel_i(sel),
    .cnt_o(w_cnt), .cycle_o(w_cyc), .snap_valid_o(w_sv), .running_o(w_run),
    .done_o(w_done), .ovf_o(w_ovf)
  );

  perf_event_counter #(.NUM_EVT(NE), .CNT_W(NW)) u_narrow (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clear), .enable_i(enable),
    .sat_mode_i(sat_mode), .limit_i(limit_n), .evt_i(evt), .snap_i(snap), .sel_i(sel),
    .cnt_o(n_cnt), .cycle_o(n_cyc), .snap_valid_o(n_sv), .running_o(n_run),
    .done_o(n_done), .ovf_o(n_ovf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = 32-bit instance, 1 = 4-bit instance; state 0/1/2 = idle/run/done
  longint unsigned m_live [2][NCH];
  longint unsigned m_shad [2][NCH];
  bit              m_ovf  [2][NCH];
  bit              m_sv   [2];
  int              m_state[2];
  longint unsigned m_lim  [2];
  bit              m_sat  [2];

  logic [63:0] o_cnt [2][NE];
  logic [63:0] o_cyc [2];
  logic [63:0] o_ovf [2];
  bit          o_sv  [2];
  bit          o_run [2];
  bit          o_done[2];

  function automatic longint unsigned maxv(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  function automatic logic [63:0] exp_ovf(input int d);
    logic [63:0] e;
    e = '0;
    for (int c = 0; c < NCH; c++) e[c] = m_ovf[d][c];
    return e;
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      longint unsigned nw[NCH];
      bit counting, bump, fin;
      if (rst || clear) begin
        for (int c = 0; c < NCH; c++) begin
          m_live[d][c] = 0; m_shad[d][c] = 0; m_ovf[d][c] = 0;
        end
        m_sv[d] = 0; m_state[d] = 0;
        if (rst) begin m_lim[d] = 0; m_sat[d] = 0; end
      end else if (start) begin
        if (snap) begin
          for (int c = 0; c < NCH; c++) m_shad[d][c] = m_live[d][c];
          m_sv[d] = 1;
        end
        for (int c = 0; c < NCH; c++) begin m_live[d][c] = 0; m_ovf[d][c] = 0; end
        m_lim[d] = 64'(limit) & maxv(d);
        m_sat[d] = sat_mode;
        m_state[d] = 1;
      end else begin
        counting = (m_state[d] == 1) && enable;
        for (int c = 0; c < NCH; c++) begin
          nw[c] = m_live[d][c];
          bump  = counting && ((c == NE) ? 1'b1 : evt[c[1:0]]);
          if (bump) begin
            if (m_live[d][c] == maxv(d)) begin
              m_ovf[d][c] = 1;
              nw[c] = m_sat[d] ? maxv(d) : 0;
            end else begin
              nw[c] = m_live[d][c] + 1;
            end
          end
        end
        fin = counting && (m_lim[d] != 0) && (nw[NE] == m_lim[d]);
        if (fin) begin
          for (int c = 0; c < NCH; c++) m_shad[d][c] = nw[c];
          m_sv[d] = 1; m_state[d] = 2;
        end else if (snap) begin
          for (int c = 0; c < NCH; c++) m_shad[d][c] = m_live[d][c];
          m_sv[d] = 1;
        end
        for (int c = 0; c < NCH; c++) m_live[d][c] = nw[c];
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    for (int s = 0; s < NE; s++) begin
      sel = 2'(s);
      #1;
      o_cnt[0][s] = 64'(w_cnt);
      o_cnt[1][s] = 64'(n_cnt);
    end
    o_cyc[0] = 64'(w_cyc);  o_cyc[1] = 64'(n_cyc);
    o_ovf[0] = 64'(w_ovf);  o_ovf[1] = 64'(n_ovf);
    o_sv[0]  = w_sv;        o_sv[1]  = n_sv;
    o_run[0] = w_run;       o_run[1] = n_run;
    o_done[0] = w_done;     o_done[1] = n_done;
  endtask

  task automatic go(input logic [WW-1:0] lim, input logic sat, input logic [NE-1:0] ev);
    limit = lim; sat_mode = sat; enable = 1'b1; evt = ev; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_run[d], o_done[d], o_sv[d]} !== 3'b000 || o_ovf[d] !== 64'd0 || o_cyc[d] !== 64'd0) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got run=%0d done=%0d sv=%0d ovf=%0h cyc=%0d required all 0",
                 d, o_run[d], o_done[d], o_sv[d], o_ovf[d], o_cyc[d]);
      end
      for (int s = 0; s < NE; s++) begin
        checks++;
        if (o_cnt[d][s] !== 64'd0) begin
          errors++;
          $display("FAIL reset_cnt[%0d][%0d]: got %0d required 0", d, s, o_cnt[d][s]);
        end
      end
    end
  endtask

  task automatic test_limit_run();
    int n;
    logic [NE-1:0] ev;
    ev = '0; ev[EVT_STALL] = 1'b1;
    go(32'd10, 1'b0, ev);
    n = 0;
    while (w_done !== 1'b1 && n < 30) begin tick(); n++; end
    checks++;
    if (n != 10 || n_done !== 1'b1) begin
      errors++;
      $display("FAIL limit_len: got %0d cycles (narrow done=%0d) required 10", n, n_done);
    end
    snap = 1'b1; tick(); snap = 1'b0; evt = '0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cyc[d] !== 64'd10 || o_sv[d] !== 1'b1 || o_done[d] !== 1'b1) begin
        errors++;
        $display("FAIL limit_cycle[%0d]: got cyc=%0d sv=%0d done=%0d required 10/1/1",
                 d, o_cyc[d], o_sv[d], o_done[d]);
      end
      for (int s = 0; s < NE; s++) begin
        checks++;
        if (o_cnt[d][s] !== ((s == EVT_STALL) ? 64'd10 : 64'd0)) begin
          errors++;
          $display("FAIL limit_cnt[%0d][%0d]: got %0d required %0d", d, s, o_cnt[d][s],
                   (s == EVT_STALL) ? 10 : 0);
        end
      end
    end
  endtask

  task automatic test_enable_pause();
    logic [NE-1:0] ev;
    ev = '0; ev[EVT_FLUSH] = 1'b1;
    go(32'd0, 1'b0, ev);
    for (int i = 0; i < 20; i++) begin
      enable = (i % 2 == 0);
      tick();
    end
    enable = 1'b0; snap = 1'b1; tick(); snap = 1'b0; evt = '0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cyc[d] !== 64'd10 || o_cnt[d][EVT_FLUSH] !== 64'd10 || o_run[d] !== 1'b1) begin
        errors++;
        $display("FAIL pause[%0d]: got cyc=%0d flush=%0d run=%0d required 10/10/1",
                 d, o_cyc[d], o_cnt[d][EVT_FLUSH], o_run[d]);
      end
    end
  endtask

  task automatic test_overflow(input logic sat);
    logic [NE-1:0] ev;
    logic [63:0] want;
    ev = '0; ev[EVT_RETIRE] = 1'b1;
    go(32'd0, sat, ev);
    repeat (18) tick();
    evt = '0; enable = 1'b0; snap = 1'b1; tick(); snap = 1'b0;
    sample();
    want = sat ? 64'd15 : 64'd2;
    checks++;
    if (o_cnt[1][EVT_RETIRE] !== want || o_cyc[1] !== want || o_ovf[1] !== 64'h11) begin
      errors++;
      $display("FAIL ovf_narrow sat=%0d: got cnt=%0d cyc=%0d ovf=%0h required %0d/%0d/11",
               sat, o_cnt[1][EVT_RETIRE], o_cyc[1], o_ovf[1], want, want);
    end
    checks++;
    if (o_cnt[0][EVT_RETIRE] !== 64'd18 || o_ovf[0] !== 64'd0) begin
      errors++;
      $display("FAIL ovf_wide sat=%0d: got cnt=%0d ovf=%0h required 18/0",
               sat, o_cnt[0][EVT_RETIRE], o_ovf[0]);
    end
  endtask

  task automatic test_snap_same_edge();
    logic [NE-1:0] ev;
    ev = '0; ev[EVT_BRANCH] = 1'b1;
    go(32'd0, 1'b0, '0);
    evt = ev;
    repeat (5) tick();
    snap = 1'b1; tick(); snap = 1'b0; evt = '0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cnt[d][EVT_BRANCH] !== 64'd5) begin
        errors++;
        $display("FAIL snap_pre[%0d]: got %0d required 5", d, o_cnt[d][EVT_BRANCH]);
      end
    end
    snap = 1'b1; tick(); snap = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cnt[d][EVT_BRANCH] !== 64'd6) begin
        errors++;
        $display("FAIL snap_post[%0d]: got %0d required 6", d, o_cnt[d][EVT_BRANCH]);
      end
    end
  endtask

  task automatic test_clear_snap();
    go(32'd0, 1'b0, 4'b1111);
    repeat (20) tick();
    snap = 1'b1; tick();
    checks++;
    if (w_sv !== 1'b1 || n_ovf === '0) begin
      errors++;
      $display("FAIL clear_pre: got sv=%0d narrow ovf=%0h required sv=1 ovf nonzero", w_sv, n_ovf);
    end
    clear = 1'b1; tick(); clear = 1'b0; snap = 1'b0; evt = '0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_run[d], o_done[d], o_sv[d]} !== 3'b000 || o_ovf[d] !== 64'd0 || o_cyc[d] !== 64'd0) begin
        errors++;
        $display("FAIL clear_flags[%0d]: got run=%0d done=%0d sv=%0d ovf=%0h cyc=%0d required all 0",
                 d, o_run[d], o_done[d], o_sv[d], o_ovf[d], o_cyc[d]);
      end
      for (int s = 0; s < NE; s++) begin
        checks++;
        if (o_cnt[d][s] !== 64'd0) begin
          errors++;
          $display("FAIL clear_cnt[%0d][%0d]: got %0d required 0", d, s, o_cnt[d][s]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    go(32'd0, 1'b0, 4'b0001);
    repeat (7) tick();
    snap = 1'b1; tick(); snap = 1'b0;
    sample();
    checks++;
    if (o_cnt[0][EVT_RETIRE] !== 64'd7) begin
      errors++;
      $display("FAIL rst_pre: got %0d required 7", o_cnt[0][EVT_RETIRE]);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({o_run[d], o_done[d], o_sv[d]} !== 3'b000 || o_ovf[d] !== 64'd0 ||
          o_cyc[d] !== 64'd0 || o_cnt[d][EVT_RETIRE] !== 64'd0) begin
        errors++;
        $display("FAIL rst_mid[%0d]: got run=%0d sv=%0d cyc=%0d cnt0=%0d required all 0",
                 d, o_run[d], o_sv[d], o_cyc[d], o_cnt[d][EVT_RETIRE]);
      end
    end
    go(32'd0, 1'b0, 4'b0001);
    repeat (3) tick();
    evt = '0; snap = 1'b1; tick(); snap = 1'b0;
    sample();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (o_cnt[d][EVT_RETIRE] !== 64'd3 || o_cyc[d] !== 64'd3 || o_run[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_restart[%0d]: got cnt0=%0d cyc=%0d run=%0d required 3/3/1",
                 d, o_cnt[d][EVT_RETIRE], o_cyc[d], o_run[d]);
      end
    end
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 500; i++) begin
      r        = $urandom_range(0, 99);
      rst      = (r < 2);
      clear    = (r >= 2 && r < 5);
      start    = (r >= 5 && r < 11);
      snap     = ($urandom_range(0, 7) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      evt      = NE'($urandom);
      sat_mode = 1'($urandom_range(0, 1));
      limit    = 32'($urandom_range(0, 24));
      tick();
      sample();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (o_run[d] !== (m_state[d] == 1) || o_done[d] !== (m_state[d] == 2) || o_sv[d] !== m_sv[d]) begin
          errors++;
          $display("FAIL rnd_state[%0d] i=%0d: got run=%0d done=%0d sv=%0d required state=%0d sv=%0d",
                   d, i, o_run[d], o_done[d], o_sv[d], m_state[d], m_sv[d]);
        end
        checks++;
        if (o_ovf[d] !== exp_ovf(d) || o_cyc[d] !== m_shad[d][NE]) begin
          errors++;
          $display("FAIL rnd_cyc[%0d] i=%0d: got ovf=%0h cyc=%0d required ovf=%0h cyc=%0d",
                   d, i, o_ovf[d], o_cyc[d], exp_ovf(d), m_shad[d][NE]);
        end
        for (int s = 0; s < NE; s++) begin
          checks++;
          if (o_cnt[d][s] !== m_shad[d][s]) begin
            errors++;
            $display("FAIL rnd_cnt[%0d][%0d] i=%0d: got %0d required %0d",
                     d, s, i, o_cnt[d][s], m_shad[d][s]);
          end
        end
      end
    end
    rst = 1'b0; clear = 1'b0; start = 1'b0; snap = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_limit_run();
    test_enable_pause();
    test_overflow(1'b0);
    test_overflow(1'b1);
    test_snap_same_edge();
    test_clear_snap();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
